accel_bus_slave: RTL and testbench

- Accelerator-side endpoint of the CPU accelerator bus.
- CPU writes are decoded into an operand FIFO and a control register; CPU reads return status words or pop a result FIFO.
- The operand FIFO feeds the NN accelerator core over valid/ready; accelerator results are buffered back for the CPU.
- Sits between the CPU bus port and the NN accelerator datapath.

---
 rtl/accel_bus_pkg.sv | 21 ++
 rtl/accel_bus_slave_fifo.sv | 40 ++++
 rtl/accel_bus_slave.sv | 96 +++++++++
 tb/tb_accel_bus_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/accel_bus_pkg.sv
// accel_bus_pkg: register map, CTRL/STATUS bit positions and FSM state for the accelerator bus slave.
package accel_bus_pkg;
    localparam logic [1:0] ADDR_OPERAND = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_RESULT  = 2'd3;
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_ERR  = 2;
    localparam int CTRL_FLUSH    = 3;
    localparam int ST_OP_FULL   = 0;
    localparam int ST_OP_EMPTY  = 1;
    localparam int ST_RES_FULL  = 2;
    localparam int ST_RES_EMPTY = 3;
    localparam int ST_BUSY      = 4;
    localparam int ST_DONE      = 5;
    localparam int ST_OVERFLOW  = 6;
    localparam int ST_UNDERFLOW = 7;
    localparam int ST_CNT_LO    = 8;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/accel_bus_slave_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/accel_bus_slave.sv
// accel_bus_slave: CPU bus endpoint decoding operand/ctrl writes and status/result reads
// for the NN accelerator, with operand and result FIFOs and an IDLE/RUN sequencer.
module accel_bus_slave
    import accel_bus_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int OP_DEPTH  = 16,
    parameter int RES_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [1:0]        bus_addr,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              acc_start,
    output logic              acc_abort,
    input  logic              acc_done,
    output logic              acc_op_valid,
    input  logic              acc_op_ready,
    output logic [DATA_W-1:0] acc_op_data,
    input  logic              acc_res_valid,
    output logic              acc_res_ready,
    input  logic [DATA_W-1:0] acc_res_data
);
    state_t                      state;
    logic                        done, overflow, underflow;
    logic                        op_full, op_empty, res_full, res_empty;
    logic [$clog2(OP_DEPTH):0]   op_count;
    logic [$clog2(RES_DEPTH):0]  res_count;
    logic [DATA_W-1:0]           res_head, status;
    logic                        wr_op, wr_ctrl, rd_res, flush, op_pop, res_push;
    assign wr_op         = bus_wr && bus_addr == ADDR_OPERAND;
    assign wr_ctrl       = bus_wr && bus_addr == ADDR_CTRL;
    assign rd_res        = bus_rd && bus_addr == ADDR_RESULT;
    assign flush         = wr_ctrl && bus_data_in[CTRL_FLUSH];
    assign acc_op_valid  = !op_empty;
    assign acc_res_ready = !res_full;
    assign op_pop        = acc_op_valid && acc_op_ready;
    assign res_push      = acc_res_valid && acc_res_ready;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(OP_DEPTH)) u_op_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_op), .pop(acc_op_ready), .flush(flush),
        .din(bus_data_in), .dout(acc_op_data), .full(op_full), .empty(op_empty), .count(op_count)
    );
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .rst_n(rst_n), .push(res_push), .pop(rd_res), .flush(flush),
        .din(acc_res_data), .dout(res_head), .full(res_full), .empty(res_empty), .count(res_count)
    );
    always_comb begin
        status = '0;
        status[ST_OP_FULL]   = op_full;
        status[ST_OP_EMPTY]  = op_empty;
        status[ST_RES_FULL]  = res_full;
        status[ST_RES_EMPTY] = res_empty;
        status[ST_BUSY]      = state == RUN;
        status[ST_DONE]      = done;
        status[ST_OVERFLOW]  = overflow;
        status[ST_UNDERFLOW] = underflow;
        status[ST_CNT_LO +: 5] = 5'(res_count);
    end
    // an empty RESULT read returns 0 rather than the stale slot under the read pointer
    assign bus_data_out = !bus_rd || bus_addr == ADDR_STATUS ? status :
                          bus_addr == ADDR_RESULT ? (res_empty ? '0 : res_head) : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            acc_start <= 1'b0;
            acc_abort <= 1'b0;
        end else begin
            acc_start <= 1'b0;
            acc_abort <= 1'b0;
            if (wr_ctrl && bus_data_in[CTRL_CLR_DONE]) done <= 1'b0;
            if (wr_ctrl && bus_data_in[CTRL_CLR_ERR]) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (wr_op && op_full && !op_pop) overflow <= 1'b1;
            if (rd_res && res_empty) underflow <= 1'b1;
            if (flush) begin
                state     <= IDLE;
                acc_abort <= state == RUN;
            end else if (state == IDLE && wr_ctrl && bus_data_in[CTRL_START]) begin
                state     <= RUN;
                acc_start <= 1'b1;
                done      <= 1'b0;
            end else if (state == RUN && acc_done) begin
                state <= IDLE;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_accel_bus_slave.sv
// tb_accel_bus_slave: scoreboard bench; operand and result queues hold the values the CPU/accelerator must see.
module tb_accel_bus_slave;
    import accel_bus_pkg::*;
    localparam int W = 16;
    logic         clk = 1'b0, rst_n = 1'b0, bus_wr = 1'b0, bus_rd = 1'b0;
    logic [1:0]   bus_addr = '0;
    logic [W-1:0] bus_data_in = '0, bus_data_out, acc_op_data, acc_res_data = '0;
    logic         acc_start, acc_abort, acc_done = 1'b0, acc_op_valid, acc_op_ready = 1'b0;
    logic         acc_res_valid = 1'b0, acc_res_ready;
    int           n_cmp = 0, n_bad = 0, start_cnt = 0, abort_cnt = 0;
    logic [W-1:0] op_q[$], res_q[$];

    accel_bus_slave #(.DATA_W(W), .OP_DEPTH(16), .RES_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .acc_start(acc_start),
        .acc_abort(acc_abort), .acc_done(acc_done), .acc_op_valid(acc_op_valid),
        .acc_op_ready(acc_op_ready), .acc_op_data(acc_op_data), .acc_res_valid(acc_res_valid),
        .acc_res_ready(acc_res_ready), .acc_res_data(acc_res_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // operands leave at the next posedge whenever valid&&ready holds at the negedge
    always @(negedge clk) begin
        if (acc_start) start_cnt++;
        if (acc_abort) abort_cnt++;
        if (acc_op_valid && acc_op_ready) begin
            if (op_q.size() == 0) check("op_unexpected", 16'(op_q.size()), 16'd1);
            else check("op_data", acc_op_data, op_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        bus_wr = 1'b1; bus_addr = a; bus_data_in = d;
        @(posedge clk); #1;
        bus_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        bus_rd = 1'b1; bus_addr = a;
        @(negedge clk);
        d = bus_data_out;
        @(posedge clk); #1;
        bus_rd = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] d;
        rd(ADDR_STATUS, d);
        check(tag, d, exp);
    endtask

    task automatic rd_result(input string tag);
        logic [W-1:0] d;
        rd(ADDR_RESULT, d);
        check(tag, d, res_q.size() != 0 ? res_q.pop_front() : 16'h0000);
    endtask

    task automatic wr_op(input logic [W-1:0] d, input bit expect_kept);
        if (expect_kept) op_q.push_back(d);
        wr(ADDR_OPERAND, d);
    endtask

    task automatic push_res(input logic [W-1:0] d);
        int i = 0;
        acc_res_valid = 1'b1; acc_res_data = d;
        @(negedge clk);
        while (!acc_res_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("res_handshake", 16'(acc_res_ready), 16'd1);
        res_q.push_back(d);
        @(posedge clk); #1;
        acc_res_valid = 1'b0;
    endtask

    task automatic wait_op_drain();
        int i = 0;
        while (acc_op_valid && i < 40) begin
            idle(1);
            i++;
        end
        check("op_drain", 16'(acc_op_valid), 16'd0);
        check("op_q_left", 16'(op_q.size()), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, a;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_idle_out", bus_data_out, 16'h000A);
        check("reset_op_valid", 16'(acc_op_valid), 16'd0);
        check("reset_res_ready", 16'(acc_res_ready), 16'd1);
        check("reset_start", 16'(acc_start), 16'd0);
        idle(1);
        chk_status("reset_status", 16'h000A);

        wr_op(16'h1111, 1); wr_op(16'h2222, 1); wr_op(16'h3333, 1);
        chk_status("op_loaded", 16'h0008);
        acc_op_ready = 1'b1;
        wait_op_drain();
        acc_op_ready = 1'b0;
        chk_status("op_drained", 16'h000A);

        for (int i = 0; i < 17; i++) wr_op(16'(16'h4000 + i), i < 16);
        chk_status("op_overflow", 16'h0049);
        wr(ADDR_CTRL, 16'h0004);
        chk_status("ovf_cleared", 16'h0009);
        acc_op_ready = 1'b1;
        wr_op(16'h4FFF, 1);
        acc_op_ready = 1'b0;
        chk_status("full_push_pop", 16'h0009);
        acc_op_ready = 1'b1;
        wait_op_drain();
        acc_op_ready = 1'b0;

        wr(ADDR_CTRL, 16'h0001);
        @(negedge clk);
        check("start_pulse", 16'(acc_start), 16'd1);
        idle(1);
        chk_status("busy", 16'h001A);
        push_res(16'hBEEF);
        acc_res_valid = 1'b1; acc_res_data = 16'hCAFE; acc_done = 1'b1;
        @(negedge clk);
        check("res_with_done", 16'(acc_res_ready), 16'd1);
        res_q.push_back(16'hCAFE);
        @(posedge clk); #1;
        acc_res_valid = 1'b0; acc_done = 1'b0;
        chk_status("done_status", 16'h0222);
        check("start_count", 16'(start_cnt), 16'd1);
        rd_result("res_1"); rd_result("res_2"); rd_result("res_underflow");
        chk_status("underflow_status", 16'h00AA);
        wr(ADDR_CTRL, 16'h0006);
        chk_status("cleared", 16'h000A);

        acc_res_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc_res_data = 16'(16'h5000 + i);
            @(negedge clk);
            check("res_fill_ready", 16'(acc_res_ready), 16'd1);
            res_q.push_back(acc_res_data);
            @(posedge clk); #1;
        end
        acc_res_data = 16'h5010;
        @(negedge clk);
        check("res_full_ready", 16'(acc_res_ready), 16'd0);
        idle(1);
        chk_status("res_full_status", 16'h1006);
        rd_result("res_pop_pending");
        @(negedge clk);
        check("res_refill_ready", 16'(acc_res_ready), 16'd1);
        res_q.push_back(16'h5010);
        @(posedge clk); #1;
        acc_res_valid = 1'b0;
        chk_status("res_refilled", 16'h1006);
        for (int i = 0; i < 16; i++) rd_result("res_order");
        chk_status("res_emptied", 16'h000A);

        wr_op(16'hA001, 1); wr_op(16'hA002, 1);
        push_res(16'hB001);
        wr(ADDR_CTRL, 16'h0001);
        idle(1);
        chk_status("run_loaded", 16'h0110);
        s = start_cnt; a = abort_cnt;
        wr(ADDR_CTRL, 16'h0009);
        @(negedge clk);
        check("abort_pulse", 16'(acc_abort), 16'd1);
        check("abort_no_start", 16'(acc_start), 16'd0);
        idle(1);
        op_q.delete(); res_q.delete();
        chk_status("flush_status", 16'h000A);
        check("flush_start_cnt", 16'(start_cnt - s), 16'd0);
        check("flush_abort_cnt", 16'(abort_cnt - a), 16'd1);

        wr_op(16'hC001, 1); wr_op(16'hC002, 1);
        push_res(16'hD001);
        wr(ADDR_CTRL, 16'h0001);
        idle(1);
        a = abort_cnt;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        op_q.delete(); res_q.delete();
        idle(2);
        chk_status("rst_run_status", 16'h000A);
        check("rst_no_abort", 16'(abort_cnt - a), 16'd0);
        check("rst_op_valid", 16'(acc_op_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
